// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution block: FSM encodings, offset shift,
// and the control-flow decode helpers used by both the FSM and the target datapath.
package branch_resolve_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_SQUASH   = 2'd2;

  // Branch offsets are in words, so they are scaled to bytes by this shift.
  localparam int unsigned BR_SHIFT = 2;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_J    = 2'd1,
    OP_BEQ  = 2'd2,
    OP_BNE  = 2'd3
  } op_e;

  // J outranks BEQ, which outranks BNE, when several decode bits are set at once.
  function automatic op_e decode_op(input logic j, input logic beq, input logic bne);
    op_e op;
    op = OP_NONE;
    if (j)        op = OP_J;
    else if (beq) op = OP_BEQ;
    else if (bne) op = OP_BNE;
    return op;
  endfunction

  function automatic logic resolve_taken(input op_e op, input logic zero);
    logic taken;
    case (op)
      OP_J:    taken = 1'b1;
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_target.sv
// Combinational branch/jump target generation: PC-relative adder for BEQ/BNE,
// region-preserving absolute address for J.
module branch_target
  import branch_resolve_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc4,
  input  logic [15:0]      imm,
  input  logic [25:0]      jaddr,
  input  logic             sel_j,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;

  always_comb begin
    // The adder wraps silently; no overflow is reported for branch targets.
    offset    = {{(WIDTH-16){imm[15]}}, imm} << BR_SHIFT;
    br_target = pc4 + offset;
    j_target  = {pc4[WIDTH-1:WIDTH-4], jaddr, 2'b00};
    target    = sel_j ? j_target : br_target;
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves one control-flow instruction per handshake, holds the redirect until the
// fetch stage acks it, squashes the wrong-path slots and keeps saturating statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SQUASH_SLOTS = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_beq,
  input  logic                 is_bne,
  input  logic                 is_j,
  input  logic [WIDTH-1:0]     in_pc4,
  input  logic [15:0]          in_imm,
  input  logic [25:0]          in_jaddr,
  input  logic                 zero,
  output logic                 redirect_valid,
  output logic [WIDTH-1:0]     redirect_pc,
  input  logic                 redirect_ack,
  output logic                 squash,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam logic [3:0] SLOTS = 4'(SQUASH_SLOTS);

  logic [1:0]           state_q, state_d;
  logic [3:0]           squash_cnt_q, squash_cnt_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;

  op_e              op;
  logic             taken;
  logic             accept;
  logic             is_cond;
  logic [WIDTH-1:0] target;

  branch_target #(
    .WIDTH (WIDTH)
  ) u_target (
    .pc4    (in_pc4),
    .imm    (in_imm),
    .jaddr  (in_jaddr),
    .sel_j  (op == OP_J),
    .target (target)
  );

  always_comb begin
    in_ready = (state_q != ST_REDIRECT);
    squash   = (state_q == ST_SQUASH);
    accept   = in_valid & in_ready;
    op       = decode_op(is_j, is_beq, is_bne);
    taken    = resolve_taken(op, zero);
    is_cond  = (op == OP_BEQ) || (op == OP_BNE);
  end

  // NOTE: every signal gets its hold value first so no path through the case leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d          = state_q;
    squash_cnt_d     = squash_cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    br_count_d       = br_count_q;
    taken_count_d    = taken_count_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (is_cond && (br_count_q != '1)) begin
            br_count_d = br_count_q + 1'b1;
          end
          if (is_cond && taken && (taken_count_q != '1)) begin
            taken_count_d = taken_count_q + 1'b1;
          end
          if (taken) begin
            redirect_pc_d    = target;
            redirect_valid_d = 1'b1;
            state_d          = ST_REDIRECT;
          end
        end
      end

      ST_REDIRECT: begin
        if (redirect_ack) begin
          redirect_valid_d = 1'b0;
          if (SLOTS == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            squash_cnt_d = SLOTS;
            state_d      = ST_SQUASH;
          end
        end
      end

      ST_SQUASH: begin
        // Wrong-path instructions are consumed blindly; their control bits never matter.
        if (accept) begin
          squash_cnt_d = squash_cnt_q - 4'd1;
          if (squash_cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from values sampled at the same clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      squash_cnt_q     <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      taken_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      squash_cnt_q     <= squash_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_count_q       <= br_count_d;
      taken_count_q    <= taken_count_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_branch_resolve;

  localparam int SLOTS = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          is_beq;
  logic          is_bne;
  logic          is_j;
  logic [31:0]   in_pc4;
  logic [15:0]   in_imm;
  logic [25:0]   in_jaddr;
  logic          zero;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          redirect_ack;
  logic          squash;
  logic [CW-1:0] br_count;
  logic [CW-1:0] taken_count;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: a pending redirect, its target, wrong-path slots still to discard,
  // and the two statistics counts.
  bit          m_pending;
  logic [31:0] m_pc;
  int          m_slots_left;
  int          m_br;
  int          m_taken;

  branch_resolve #(
    .WIDTH        (32),
    .SQUASH_SLOTS (SLOTS),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .is_beq         (is_beq),
    .is_bne         (is_bne),
    .is_j           (is_j),
    .in_pc4         (in_pc4),
    .in_imm         (in_imm),
    .in_jaddr       (in_jaddr),
    .zero           (zero),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ack   (redirect_ack),
    .squash         (squash),
    .br_count       (br_count),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_outputs(input string where);
    check($sformatf("%s@%0d.in_ready", where, cyc), 32'(in_ready), 32'(!m_pending));
    check($sformatf("%s@%0d.squash", where, cyc), 32'(squash),
          32'(!m_pending && (m_slots_left > 0)));
    check($sformatf("%s@%0d.redirect_valid", where, cyc), 32'(redirect_valid), 32'(m_pending));
    check($sformatf("%s@%0d.redirect_pc", where, cyc), redirect_pc, m_pc);
    check($sformatf("%s@%0d.br_count", where, cyc), 32'(br_count), 32'(m_br));
    check($sformatf("%s@%0d.taken_count", where, cyc), 32'(taken_count), 32'(m_taken));
  endtask

  task automatic model_reset();
    m_pending    = 1'b0;
    m_pc         = 32'h0;
    m_slots_left = 0;
    m_br         = 0;
    m_taken      = 0;
  endtask

  task automatic model_update(input bit v, input bit beq, input bit bne, input bit j,
                              input bit z, input bit ack, input logic [31:0] pc4,
                              input logic [15:0] imm, input logic [25:0] jaddr);
    bit          tk;
    logic [31:0] tgt;
    int          off;
    tk  = 1'b0;
    tgt = 32'h0;
    if (m_pending) begin
      if (ack) begin
        m_pending    = 1'b0;
        m_slots_left = SLOTS;
      end
    end else if (v) begin
      if (m_slots_left > 0) begin
        m_slots_left--;
      end else begin
        if (j) begin
          tk  = 1'b1;
          tgt = {pc4[31:28], jaddr, 2'b00};
        end else if (beq || bne) begin
          m_br = sat_inc(m_br);
          tk   = beq ? z : !z;
          off  = int'($signed(imm)) * 4;
          tgt  = pc4 + 32'(off);
          if (tk) m_taken = sat_inc(m_taken);
        end
        if (tk) begin
          m_pending = 1'b1;
          m_pc      = tgt;
        end
      end
    end
  endtask

  // One clock: drive inputs, compare current outputs, advance model, move past the edge.
  task automatic step(input bit v, input bit beq, input bit bne, input bit j, input bit z,
                      input bit ack, input logic [31:0] pc4, input logic [15:0] imm,
                      input logic [25:0] jaddr);
    in_valid     = v;
    is_beq       = beq;
    is_bne       = bne;
    is_j         = j;
    zero         = z;
    redirect_ack = ack;
    in_pc4       = pc4;
    in_imm       = imm;
    in_jaddr     = jaddr;
    check_outputs("step");
    model_update(v, beq, bne, j, z, ack, pc4, imm, jaddr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit ack);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ack, 32'h0, 16'h0, 26'h0);
  endtask

  // Reset is raised away from the clock edge and checked before the next edge.
  task automatic do_reset();
    reset        = 1'b1;
    in_valid     = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_j         = 1'b0;
    zero         = 1'b0;
    redirect_ack = 1'b0;
    #2;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    #1;
    do_reset();

    // 1: taken BEQ, target 0x110 visible one cycle later.
    step(1, 1, 0, 0, 1, 0, 32'h0000_0100, 16'h0004, 26'h0);
    check("t1.redirect_valid", 32'(redirect_valid), 32'h1);
    check("t1.redirect_pc", redirect_pc, 32'h0000_0110);
    check("t1.br_count", 32'(br_count), 32'h1);
    check("t1.taken_count", 32'(taken_count), 32'h1);

    // 2: untaken BNE, input accepted again the following cycle.
    do_reset();
    step(1, 0, 1, 0, 1, 0, 32'h0000_0200, 16'h0010, 26'h0);
    check("t2.in_ready", 32'(in_ready), 32'h1);
    check("t2.taken_count", 32'(taken_count), 32'h0);
    step(1, 0, 1, 0, 1, 0, 32'h0000_0204, 16'h0010, 26'h0);
    check("t2.br_count", 32'(br_count), 32'h2);

    // 3: backward branch wrapping below zero, long ack stall, then squash window.
    do_reset();
    step(1, 1, 0, 0, 1, 0, 32'h0000_0004, 16'hFFFE, 26'h0);
    check("t3.redirect_pc", redirect_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 1, 0, 32'h1000, 16'h1, 26'h0);
    check("t3.pc_stable", redirect_pc, 32'hFFFF_FFFC);
    idle(1'b1);
    check("t3.squash1", 32'(squash), 32'h1);
    step(1, 1, 0, 0, 1, 0, 32'h2000, 16'h1, 26'h0);
    check("t3.squash2", 32'(squash), 32'h1);
    step(1, 1, 0, 0, 1, 0, 32'h2004, 16'h1, 26'h0);
    check("t3.squash3", 32'(squash), 32'h0);
    step(1, 0, 1, 0, 1, 0, 32'h2008, 16'h1, 26'h0);

    // 4: J wins over simultaneous BEQ; counters untouched.
    do_reset();
    step(1, 1, 0, 1, 1, 0, 32'hA000_0000, 16'h0004, 26'h3FF_FFFF);
    check("t4.redirect_pc", redirect_pc, 32'hAFFF_FFFC);
    check("t4.br_count", 32'(br_count), 32'h0);
    check("t4.taken_count", 32'(taken_count), 32'h0);

    // 5: reset in the middle of REDIRECT, then in the middle of SQUASH.
    do_reset();
    step(1, 0, 1, 0, 0, 0, 32'h0000_0040, 16'h0008, 26'h0);
    idle(1'b0);
    do_reset();
    step(1, 0, 1, 0, 0, 0, 32'h0000_0040, 16'h0008, 26'h0);
    idle(1'b1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
    do_reset();
    check("t5.in_ready", 32'(in_ready), 32'h1);

    // 6: br_count saturates after 2^CW untaken BNEs.
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      step(1, 0, 1, 0, 1, 0, 32'(i * 4), 16'h0100, 26'h0);
    end
    check("t6.br_sat", 32'(br_count), 32'hF);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom, 16'($urandom), 26'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
